control_puertas: RTL and testbench

//  Door-side responder of the elevator controller. Takes the door-cycle request the

---
 rtl/puertas_pkg.sv | 35 +++
 rtl/temporizador_puertas.sv | 32 +++
 rtl/control_puertas.sv | 137 +++++++++++++
 tb/tb_control_puertas.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puertas_pkg.sv
// Shared encodings for the elevator door controller: FSM states, actuator commands
// and door feedback codes.
package puertas_pkg;

    typedef enum logic [2:0] {
        CERRADA  = 3'd0,
        ABRIENDO = 3'd1,
        ABIERTA  = 3'd2,
        CERRANDO = 3'd3,
        FALLA    = 3'd4
    } estado_t;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        OPEN  = 2'b01,
        CLOSE = 2'b10
    } cmd_t;

    typedef enum logic [1:0] {
        MOV   = 2'b00,
        CERR  = 2'b01,
        ABIER = 2'b10,
        FALLO = 2'b11
    } fb_t;

    // Actuator command driven while resting in a given state.
    function automatic cmd_t cmd_de_estado(estado_t s);
        case (s)
            ABRIENDO: return OPEN;
            CERRANDO: return CLOSE;
            default:  return HOLD;
        endcase
    endfunction

endpackage

// File: rtl/temporizador_puertas.sv
// Loadable, saturating down-counter used for both the open dwell and the stroke timeout.
// ultimo_c flags the tick on which the count lands on zero.
module temporizador_puertas #(
    parameter int unsigned W_CNT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             carga,
    input  logic             decrementa,
    input  logic [W_CNT-1:0] valor,
    output logic             cero,
    output logic             ultimo_c
);

    logic [W_CNT-1:0] cuenta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
            cero     <= 1'b1;
        end else if (carga) begin
            cuenta_q <= valor;
            cero     <= (valor == '0);
        end else if (decrementa && !cero) begin
            cuenta_q <= cuenta_q - W_CNT'(1);
            cero     <= (cuenta_q == W_CNT'(1));
        end
    end

    assign ultimo_c = (cuenta_q == W_CNT'(1));

endmodule

// File: rtl/control_puertas.sv
// Door-side responder of the elevator controller: runs the open-dwell-close cycle,
// acknowledges req_ciclo with a 4-phase listo, and interlocks the cabin motor.
module control_puertas
    import puertas_pkg::*;
#(
    parameter int unsigned T_ABIERTA = 300,
    parameter int unsigned T_MOV     = 200,
    parameter int unsigned W_CNT     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ciclo,
    output logic       listo,
    input  logic       moviendo,
    input  logic [1:0] boton_puertas,
    input  logic [1:0] estado_puertas,
    input  logic       sensor_puertas,
    output logic [1:0] puertas,
    output logic       puerta_cerrada,
    output logic       falla
);

    localparam logic [W_CNT-1:0] CARGA_ABIERTA = W_CNT'(T_ABIERTA);
    localparam logic [W_CNT-1:0] CARGA_MOV     = W_CNT'(T_MOV);

    estado_t          estado_q, estado_d;
    logic             hecho_q;
    logic             hecho_set;
    logic             carga;
    logic             decrementa;
    logic [W_CNT-1:0] valor;
    logic             cero;
    logic             ultimo_c;
    logic             expira;
    logic             reabrir;
    logic             causa_falla;

    temporizador_puertas #(
        .W_CNT(W_CNT)
    ) u_temporizador (
        .clk       (clk),
        .rst_n     (rst_n),
        .carga     (carga),
        .decrementa(decrementa),
        .valor     (valor),
        .cero      (cero),
        .ultimo_c  (ultimo_c)
    );

    // Timeout fires on the tick that brings the count to zero (or if already there).
    assign expira      = cero | ultimo_c;
    assign reabrir     = sensor_puertas | boton_puertas[0];
    assign causa_falla = (estado_puertas == FALLO) | (moviendo & (estado_q != CERRADA));

    always_comb begin
        estado_d   = estado_q;
        carga      = 1'b0;
        decrementa = 1'b0;
        valor      = CARGA_MOV;
        hecho_set  = 1'b0;
        case (estado_q)
            CERRADA: begin
                if (!moviendo && ((req_ciclo && !hecho_q) || boton_puertas[0])) begin
                    estado_d = ABRIENDO;
                    carga    = 1'b1;
                end
            end
            ABRIENDO: begin
                decrementa = 1'b1;
                if (estado_puertas == ABIER) begin
                    estado_d = ABIERTA;
                    carga    = 1'b1;
                    valor    = CARGA_ABIERTA;
                end else if (expira) begin
                    estado_d = FALLA;
                end
            end
            ABIERTA: begin
                decrementa = 1'b1;
                if (reabrir) begin
                    carga = 1'b1;
                    valor = CARGA_ABIERTA;
                end else if (boton_puertas[1] || expira) begin
                    estado_d = CERRANDO;
                    carga    = 1'b1;
                end
            end
            CERRANDO: begin
                decrementa = 1'b1;
                if (reabrir) begin
                    estado_d = ABRIENDO;
                    carga    = 1'b1;
                end else if (estado_puertas == CERR) begin
                    estado_d  = CERRADA;
                    hecho_set = req_ciclo;
                end else if (expira) begin
                    estado_d = FALLA;
                end
            end
            FALLA:   estado_d = FALLA;
            default: estado_d = FALLA;
        endcase
        // Safety causes override everything else in the same cycle.
        if (causa_falla) begin
            estado_d  = FALLA;
            carga     = 1'b0;
            hecho_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q       <= CERRADA;
            puertas        <= HOLD;
            puerta_cerrada <= 1'b1;
            falla          <= 1'b0;
            hecho_q        <= 1'b0;
            listo          <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            puertas        <= cmd_de_estado(estado_d);
            puerta_cerrada <= (estado_d == CERRADA);
            falla          <= (estado_d == FALLA);
            // 4-phase ack: listo follows hecho while resting closed; both drop with req.
            if (!req_ciclo) begin
                hecho_q <= 1'b0;
                listo   <= 1'b0;
            end else begin
                if (hecho_set) begin
                    hecho_q <= 1'b1;
                end
                listo <= hecho_q & (estado_d == CERRADA);
            end
        end
    end

endmodule

// File: tb/tb_control_puertas.sv
// Bench for control_puertas: randomized door cycles whose expected output trace is
// derived from stroke/dwell durations, followed by directed fault and reset cases.
module tb_control_puertas;

    localparam int unsigned T_AB = 8;
    localparam int unsigned T_MV = 5;

    // {puertas, listo, puerta_cerrada, falla}
    localparam logic [4:0] O_CERR   = 5'b00_0_1_0;
    localparam logic [4:0] O_LISTO  = 5'b00_1_1_0;
    localparam logic [4:0] O_ABRE   = 5'b01_0_0_0;
    localparam logic [4:0] O_ABIER  = 5'b00_0_0_0;
    localparam logic [4:0] O_CIERRA = 5'b10_0_0_0;
    localparam logic [4:0] O_FALLA  = 5'b00_0_0_1;

    logic       clk;
    logic       rst_n;
    logic       req_ciclo;
    logic       listo;
    logic       moviendo;
    logic [1:0] boton_puertas;
    logic [1:0] estado_puertas;
    logic       sensor_puertas;
    logic [1:0] puertas;
    logic       puerta_cerrada;
    logic       falla;
    logic [4:0] obs;

    int n_chk;
    int n_pass;
    int n_fail;

    control_puertas #(
        .T_ABIERTA(T_AB),
        .T_MOV    (T_MV),
        .W_CNT    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_ciclo     (req_ciclo),
        .listo         (listo),
        .moviendo      (moviendo),
        .boton_puertas (boton_puertas),
        .estado_puertas(estado_puertas),
        .sensor_puertas(sensor_puertas),
        .puertas       (puertas),
        .puerta_cerrada(puerta_cerrada),
        .falla         (falla)
    );

    assign obs = {puertas, listo, puerta_cerrada, falla};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [4:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: {puertas,listo,cerrada,falla} got %b expected %b at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    // Current sample already shows OPEN; door reports fully open after d samples.
    task automatic abrir(input int d);
        for (int i = 1; i <= d; i++) begin
            chk("abriendo", O_ABRE);
            estado_puertas = (i == d) ? 2'b10 : 2'b00;
            paso();
        end
    endtask

    // Dwell: 0 plain, 1 reload with both buttons at k, 2 reload with sensor at k,
    // 3 close button at k. Ends with CLOSE on the current sample.
    task automatic permanecer(input int modo, input int k);
        int total;
        total = (modo == 3) ? k : ((modo == 0) ? int'(T_AB) : k + int'(T_AB));
        for (int i = 1; i <= total; i++) begin
            chk("abierta", O_ABIER);
            boton_puertas  = (modo == 1 && i == k) ? 2'b11 :
                             (modo == 3 && i == k) ? 2'b10 : 2'b00;
            sensor_puertas = (modo == 2 && i == k);
            paso();
        end
        boton_puertas  = 2'b00;
        sensor_puertas = 1'b0;
    endtask

    // Closing stroke of d samples; obst>0 blocks the doors at that sample instead.
    task automatic cerrar(input int d, input int obst);
        for (int i = 1; i <= d; i++) begin
            chk("cerrando", O_CIERRA);
            if (i == obst) begin
                sensor_puertas = 1'b1;
                estado_puertas = 2'b00;
                paso();
                sensor_puertas = 1'b0;
                break;
            end
            estado_puertas = (i == d) ? 2'b01 : 2'b00;
            paso();
        end
    endtask

    task automatic reinicio(input string tag);
        rst_n          = 1'b0;
        req_ciclo      = 1'b0;
        moviendo       = 1'b0;
        boton_puertas  = 2'b00;
        sensor_puertas = 1'b0;
        estado_puertas = 2'b01;
        #1;
        chk(tag, O_CERR);
        paso();
        rst_n = 1'b1;
        paso();
        chk("tras_reset", O_CERR);
    endtask

    initial begin
        int  d_ab, d_ci, modo, k, obst, extra;
        bit  por_boton, suelta;
        n_chk = 0;
        n_pass = 0;
        n_fail = 0;
        rst_n          = 1'b0;
        req_ciclo      = 1'b0;
        moviendo       = 1'b0;
        boton_puertas  = 2'b00;
        sensor_puertas = 1'b0;
        estado_puertas = 2'b01;
        paso();
        paso();
        chk("reset", O_CERR);
        rst_n = 1'b1;
        paso();
        chk("reposo", O_CERR);

        // Randomized full door cycles
        for (int it = 0; it < 24; it++) begin
            d_ab      = int'($urandom_range(1, T_MV));
            d_ci      = int'($urandom_range(1, T_MV));
            modo      = int'($urandom_range(0, 3));
            k         = int'($urandom_range(1, T_AB));
            obst      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, d_ci)) : 0;
            por_boton = ($urandom_range(0, 3) == 0);
            suelta    = !por_boton && ($urandom_range(0, 3) == 0);

            if (por_boton) boton_puertas = 2'b01;
            else           req_ciclo     = 1'b1;
            paso();
            boton_puertas = 2'b00;
            abrir(d_ab);
            if (suelta) req_ciclo = 1'b0;
            permanecer(modo, k);
            if (obst != 0) begin
                cerrar(d_ci, obst);
                abrir(d_ab);
                permanecer(0, 0);
            end
            cerrar(d_ci, 0);
            chk("cerrada", O_CERR);
            paso();
            if (req_ciclo) begin
                chk("listo", O_LISTO);
                extra = int'($urandom_range(0, 2));
                for (int j = 0; j < extra; j++) begin
                    paso();
                    chk("listo_mantiene", O_LISTO);
                end
                req_ciclo = 1'b0;
                paso();
                chk("listo_baja", O_CERR);
            end else begin
                chk("sin_ack", O_CERR);
                paso();
                chk("sin_ack2", O_CERR);
            end
        end

        // Actuator fault reported while closed
        estado_puertas = 2'b11;
        paso();
        chk("fallo_actuador", O_FALLA);
        estado_puertas = 2'b01;
        paso();
        chk("fallo_persiste", O_FALLA);
        reinicio("reset_falla");

        // Open stroke never completes
        req_ciclo = 1'b1;
        paso();
        estado_puertas = 2'b00;
        for (int i = 0; i < int'(T_MV); i++) begin
            chk("timeout_abre", O_ABRE);
            paso();
        end
        chk("timeout_falla", O_FALLA);
        req_ciclo     = 1'b0;
        boton_puertas = 2'b01;
        for (int i = 0; i < 3; i++) begin
            paso();
            chk("timeout_persiste", O_FALLA);
        end
        reinicio("reset_timeout");

        // Motor interlock: no open while moving, fault if moving with door open
        moviendo  = 1'b1;
        req_ciclo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            paso();
            chk("interlock", O_CERR);
        end
        moviendo = 1'b0;
        paso();
        abrir(2);
        chk("interlock_abierta", O_ABIER);
        moviendo = 1'b1;
        paso();
        chk("motor_abierta", O_FALLA);
        reinicio("reset_motor");

        // Async reset while opening
        req_ciclo = 1'b1;
        paso();
        chk("pre_reset", O_ABRE);
        reinicio("reset_trayecto");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
